msrv32_wb_ctrl_unit: RTL and testbench
======================================

Name: msrv32_wb_ctrl_unit

Overview:
Writeback-stage controller that sequences the writeback select mux and the integer register-file write port. It registers the decoded writeback select, destination register and write intent from the issue stage, and holds the pipeline while a load waits for its data-memory response. It then emits exactly one register-file write strobe per retired instruction. Flush and illegal-select conditions suppress the write. It sits between the decoder/issue stage and the writeback select mux / register file.

Parameters:
LOAD_TIMEOUT, 16, max cycles spent in LOAD_WAIT before the load is abandoned (>=2)
CNT_W, 5, width of timeout counter; must hold LOAD_TIMEOUT

Ports:
ms_riscv32_mp_clk_in  in  1  clock, all state updates on rising edge
ms_riscv32_mp_rst_in  in  1  reset, synchronous, active-high
valid_in  in  1  instruction presented by issue stage this cycle
wb_mux_sel_in  in  3  decoded writeback select (0 ALU, 1 LU, 2 IMM, 3 IADDER, 4 CSR, 5 PC+4)
rf_wr_en_in  in  1  instruction writes rd
rd_addr_in  in  5  destination register
is_load_in  in  1  instruction is a load (sel must be 1)
dmem_ack_in  in  1  data-memory response valid for outstanding load
flush_in  in  1  trap/redirect: kill current and pending writeback
wb_mux_sel_reg_out  out  3  registered select driving the writeback mux
rf_wr_en_out  out  1  register-file write strobe, one cycle per write
rd_addr_out  out  5  registered destination register
stall_out  out  1  hold issue stage; high in LOAD_WAIT
wb_valid_out  out  1  one-cycle pulse: instruction retired (write or not)
load_fault_out  out  1  one-cycle pulse: load timed out
illegal_sel_out  out  1  one-cycle pulse: sel 6/7 with write requested

Behaviour:
- Reset (synchronous, active-high): state IDLE; counter 0; all outputs 0. Reset mid-LOAD_WAIT abandons the load with no write and no pulses.
- States: IDLE, LOAD_WAIT.
- IDLE, valid_in=1, flush_in=0, is_load_in=0: next cycle wb_mux_sel_reg_out=sel, rd_addr_out=rd, rf_wr_en_out=rf_wr_en_in && rd!=0 && sel<=5, wb_valid_out=1. Latency is 1 cycle. Back-to-back issue gives one write per cycle.
- IDLE, valid_in=1, flush_in=0, is_load_in=1: register sel/rd/wr intent. Go to LOAD_WAIT with counter=0. stall_out=1 starting the next cycle. No strobe yet.
- LOAD_WAIT: counter increments each cycle. Inputs valid_in/sel/rd are ignored, since the issue stage is stalled.
  - dmem_ack_in=1: next cycle rf_wr_en_out=intent && rd!=0, wb_valid_out=1, state IDLE, stall_out=0. The ack cycle itself still has stall_out=1.
  - counter==LOAD_TIMEOUT-1 without ack: next cycle load_fault_out=1, wb_valid_out=0, no write, state IDLE.
  - Ack and timeout in the same cycle: ack wins.
- flush_in has highest priority (below reset):
  - In IDLE, the same-cycle instruction is dropped: no strobe, no wb_valid_out.
  - In LOAD_WAIT, return to IDLE next cycle with no write, even if dmem_ack_in=1 that cycle.
  - A late ack arriving in IDLE is ignored.
- sel 6/7 with rf_wr_en_in=1: no write, wb_mux_sel_reg_out=0, wb_valid_out=1, illegal_sel_out=1 for one cycle.
- rd=0: wb_valid_out still pulses; rf_wr_en_out stays 0.
- rf_wr_en_out, wb_valid_out, load_fault_out and illegal_sel_out are single-cycle pulses; they deassert the next cycle unless re-triggered.
- wb_mux_sel_reg_out and rd_addr_out hold their last value when no new instruction is accepted.
- stall_out is driven from the state register only (no combinational path from inputs).

Decomposition:
- Shared package msrv32_pkg: WB_* select encodings (3'd0..3'd5), wb_state_t enum {WB_IDLE, WB_LOAD_WAIT}, REG_ZERO=5'd0.
- One sub-module: msrv32_wb_timeout_ctr, with clear, enable and terminal-count output.
- FSM, capture registers and output pulses stay in the top module.

Test Plan:
- Reset then ALU op (valid=1, sel=0, rd=5, wr=1) -> next cycle sel_out=0, rd_out=5, rf_wr_en=1, wb_valid=1; the following cycle both are 0.
- Load (sel=1, rd=7), ack 3 cycles later -> stall_out high for 4 cycles, rf_wr_en=1 with rd_out=7 the cycle after ack, single strobe.
- Load with no ack, LOAD_TIMEOUT=16 -> load_fault_out pulses exactly once, 16 cycles after entry; no write; stall_out drops; next ALU op writes normally.
- Load, then flush_in and dmem_ack_in together on cycle 2 -> no write, IDLE next cycle; a later stray ack produces no strobe.
- sel=6, wr=1, rd=3 -> illegal_sel_out=1, sel_out=0, rf_wr_en=0, wb_valid=1.
- ALU op with rd=0 -> wb_valid=1, rf_wr_en=0. Separately, assert reset during LOAD_WAIT -> all outputs 0 the next cycle, state IDLE.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared encodings for the msrv32 writeback stage: mux selects, FSM states
// and the hard-wired zero register.
package msrv32_pkg;

    localparam logic [2:0] WB_ALU    = 3'd0;
    localparam logic [2:0] WB_LU     = 3'd1;
    localparam logic [2:0] WB_IMM    = 3'd2;
    localparam logic [2:0] WB_IADDER = 3'd3;
    localparam logic [2:0] WB_CSR    = 3'd4;
    localparam logic [2:0] WB_PC4    = 3'd5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        WB_IDLE      = 1'b0,
        WB_LOAD_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/msrv32_wb_timeout_ctr.sv
// Load-wait cycle counter: clears while idle, counts while waiting, flags the
// last permitted wait cycle.
module msrv32_wb_timeout_ctr #(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(LOAD_TIMEOUT - 1));

endmodule

// File: rtl/msrv32_wb_ctrl_unit.sv
// Writeback controller: registers select/rd/write intent, waits for load
// data, and issues one register-file write strobe per retired instruction.
module msrv32_wb_ctrl_unit
    import msrv32_pkg::*;
#(
    parameter int LOAD_TIMEOUT = 16,
    parameter int CNT_W        = 5
) (
    input  logic       ms_riscv32_mp_clk_in,
    input  logic       ms_riscv32_mp_rst_in,
    input  logic       valid_in,
    input  logic [2:0] wb_mux_sel_in,
    input  logic       rf_wr_en_in,
    input  logic [4:0] rd_addr_in,
    input  logic       is_load_in,
    input  logic       dmem_ack_in,
    input  logic       flush_in,
    output logic [2:0] wb_mux_sel_reg_out,
    output logic       rf_wr_en_out,
    output logic [4:0] rd_addr_out,
    output logic       stall_out,
    output logic       wb_valid_out,
    output logic       load_fault_out,
    output logic       illegal_sel_out
);

    wb_state_t  state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [4:0] rd_q, rd_d;
    logic       intent_q, intent_d;
    logic       wr_q, wr_d;
    logic       valid_q, valid_d;
    logic       fault_q, fault_d;
    logic       ill_q, ill_d;
    logic       timeout_tc;
    logic       sel_illegal;

    assign sel_illegal = (wb_mux_sel_in > WB_PC4);

    msrv32_wb_timeout_ctr #(
        .LOAD_TIMEOUT (LOAD_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_timeout_ctr (
        .clk_i (ms_riscv32_mp_clk_in),
        .rst_i (ms_riscv32_mp_rst_in),
        .clr_i (state_q != WB_LOAD_WAIT),
        .en_i  (state_q == WB_LOAD_WAIT),
        .tc_o  (timeout_tc)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rd_d     = rd_q;
        intent_d = intent_q;
        wr_d     = 1'b0;
        valid_d  = 1'b0;
        fault_d  = 1'b0;
        ill_d    = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (valid_in && !flush_in) begin
                    rd_d = rd_addr_in;
                    if (is_load_in) begin
                        sel_d    = wb_mux_sel_in;
                        intent_d = rf_wr_en_in;
                        state_d  = WB_LOAD_WAIT;
                    end else if (sel_illegal && rf_wr_en_in) begin
                        // illegal select with a write: retire, but park the mux on ALU
                        sel_d   = WB_ALU;
                        ill_d   = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        sel_d   = wb_mux_sel_in;
                        wr_d    = rf_wr_en_in && (rd_addr_in != REG_ZERO) && !sel_illegal;
                        valid_d = 1'b1;
                    end
                end
            end
            WB_LOAD_WAIT: begin
                if (flush_in) begin
                    state_d = WB_IDLE;
                end else if (dmem_ack_in) begin
                    wr_d    = intent_q && (rd_q != REG_ZERO);
                    valid_d = 1'b1;
                    state_d = WB_IDLE;
                end else if (timeout_tc) begin
                    fault_d = 1'b1;
                    state_d = WB_IDLE;
                end
            end
            default: state_d = WB_IDLE;
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q  <= WB_IDLE;
            sel_q    <= WB_ALU;
            rd_q     <= REG_ZERO;
            intent_q <= 1'b0;
            wr_q     <= 1'b0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rd_q     <= rd_d;
            intent_q <= intent_d;
            wr_q     <= wr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
            ill_q    <= ill_d;
        end
    end

    assign wb_mux_sel_reg_out = sel_q;
    assign rd_addr_out        = rd_q;
    assign rf_wr_en_out       = wr_q;
    assign wb_valid_out       = valid_q;
    assign load_fault_out     = fault_q;
    assign illegal_sel_out    = ill_q;
    assign stall_out          = (state_q == WB_LOAD_WAIT);

endmodule

// File: tb/tb_msrv32_wb_ctrl_unit.sv
// Scoreboard bench for msrv32_wb_ctrl_unit: directed stimulus pushes expected
// writeback events; a negedge monitor pops and compares each one it sees.
module tb_msrv32_wb_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [2:0] sel_in = 3'd0;
    logic       wr_in = 1'b0;
    logic [4:0] rd_in = 5'd0;
    logic       load_in = 1'b0;
    logic       ack_in = 1'b0;
    logic       flush_in = 1'b0;
    logic [2:0] sel_out;
    logic       wr_out;
    logic [4:0] rd_out;
    logic       stall_out;
    logic       valid_out;
    logic       fault_out;
    logic       ill_out;

    typedef struct {
        logic [2:0] sel;
        logic [4:0] rd;
        logic       wr;
        logic       vld;
        logic       flt;
        logic       ill;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    msrv32_wb_ctrl_unit #(.LOAD_TIMEOUT(16), .CNT_W(5)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .valid_in             (valid_in),
        .wb_mux_sel_in        (sel_in),
        .rf_wr_en_in          (wr_in),
        .rd_addr_in           (rd_in),
        .is_load_in           (load_in),
        .dmem_ack_in          (ack_in),
        .flush_in             (flush_in),
        .wb_mux_sel_reg_out   (sel_out),
        .rf_wr_en_out         (wr_out),
        .rd_addr_out          (rd_out),
        .stall_out            (stall_out),
        .wb_valid_out         (valid_out),
        .load_fault_out       (fault_out),
        .illegal_sel_out      (ill_out)
    );

    // monitor: every cycle showing any writeback event must match the next expectation
    always @(negedge clk) begin
        if (cyc > 0 && (valid_out || wr_out || fault_out || ill_out)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL wb_event cyc=%0d: got sel=%0d rd=%0d wr=%0b vld=%0b flt=%0b ill=%0b, expected no event",
                         cyc, sel_out, rd_out, wr_out, valid_out, fault_out, ill_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (sel_out !== e.sel || rd_out !== e.rd || wr_out !== e.wr || valid_out !== e.vld ||
                    fault_out !== e.flt || ill_out !== e.ill || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL wb_event: got cyc=%0d sel=%0d rd=%0d wr=%0b vld=%0b flt=%0b ill=%0b, expected cyc=%0d sel=%0d rd=%0d wr=%0b vld=%0b flt=%0b ill=%0b",
                             cyc, sel_out, rd_out, wr_out, valid_out, fault_out, ill_out,
                             e.cyc, e.sel, e.rd, e.wr, e.vld, e.flt, e.ill);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [4:0] r, input logic w,
                         input logic ld, input logic ak, input logic fl);
        valid_in = v; sel_in = s; rd_in = r; wr_in = w; load_in = ld; ack_in = ak; flush_in = fl;
    endtask

    task automatic idle_in();
        drive(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_at(input logic [2:0] s, input logic [4:0] r, input logic w, input logic v,
                           input logic f, input logic i, input int c);
        exp_t e;
        e.sel = s; e.rd = r; e.wr = w; e.vld = v; e.flt = f; e.ill = i; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // expectation for inputs driven now, visible after the next edge
    task automatic expect_next(input logic [2:0] s, input logic [4:0] r, input logic w, input logic v,
                               input logic f, input logic i);
        push_at(s, r, w, v, f, i, cyc + 1);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic issue_alu(input logic [2:0] s, input logic [4:0] r, input logic w,
                             input logic ew, input logic [2:0] es, input logic ei);
        drive(1'b1, s, r, w, 1'b0, 1'b0, 1'b0);
        expect_next(es, r, ew, 1'b1, 1'b0, ei);
        step();
        idle_in();
    endtask

    initial begin
        int t0;
        idle_in();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_outputs", {sel_out, rd_out, wr_out, valid_out, fault_out, ill_out, stall_out}, 32'd0);

        // ALU op, then quiet cycle
        issue_alu(3'd0, 5'd5, 1'b1, 1'b1, 3'd0, 1'b0);
        step();
        check("alu_pulse_drop", {wr_out, valid_out}, 32'd0);
        check("alu_rd_hold", rd_out, 32'd5);

        // back-to-back issue
        drive(1'b1, 3'd2, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_next(3'd2, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'd5, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_next(3'd5, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        issue_alu(3'd4, 5'd10, 1'b0, 1'b0, 3'd4, 1'b0);
        step();

        // load acked on the fourth wait cycle
        drive(1'b1, 3'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle_in();
        for (int i = 0; i < 3; i++) begin
            check("load_stall", stall_out, 32'd1);
            step();
        end
        check("load_stall_ack_cycle", stall_out, 32'd1);
        ack_in = 1'b1;
        expect_next(3'd1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        ack_in = 1'b0;
        check("load_stall_release", stall_out, 32'd0);
        step();

        // load timeout
        drive(1'b1, 3'd1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle_in();
        t0 = cyc;
        push_at(3'd1, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, t0 + 16);
        for (int i = 1; i < 16; i++) begin
            step();
            if (stall_out !== 1'b1) check("timeout_stall", stall_out, 32'd1);
        end
        step();
        check("timeout_stall_release", stall_out, 32'd0);
        issue_alu(3'd3, 5'd4, 1'b1, 1'b1, 3'd3, 1'b0);
        step();

        // flush with ack in the same wait cycle, then a stray ack
        drive(1'b1, 3'd1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle_in();
        step();
        flush_in = 1'b1;
        ack_in = 1'b1;
        step();
        idle_in();
        check("flush_exit_stall", stall_out, 32'd0);
        step();
        ack_in = 1'b1;
        step();
        ack_in = 1'b0;
        step();
        check("flush_rd_hold", rd_out, 32'd8);

        // illegal select with write
        issue_alu(3'd6, 5'd3, 1'b1, 1'b0, 3'd0, 1'b1);
        step();
        // rd = 0 retires without a write
        issue_alu(3'd0, 5'd0, 1'b1, 1'b0, 3'd0, 1'b0);
        step();
        // flush in IDLE drops the instruction
        drive(1'b1, 3'd2, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
        step();
        idle_in();
        step();
        check("idle_flush_rd_hold", rd_out, 32'd0);

        // reset during LOAD_WAIT, coincident ack ignored
        drive(1'b1, 3'd1, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        idle_in();
        check("reset_case_stall", stall_out, 32'd1);
        step();
        rst = 1'b1;
        ack_in = 1'b1;
        step();
        rst = 1'b0;
        ack_in = 1'b0;
        check("midload_reset_outputs", {sel_out, rd_out, wr_out, valid_out, fault_out, ill_out, stall_out}, 32'd0);
        issue_alu(3'd0, 5'd13, 1'b1, 1'b1, 3'd0, 1'b0);
        repeat (4) step();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
